dcache_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_sram.sv | 53 +++++
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

  localparam int LINES     = 32;
  localparam int LINE_BITS = 256;
  localparam int ADDR_W    = 32;
  localparam int WORDS     = LINE_BITS / 32;
  localparam int OFS_W     = 5;
  localparam int WSEL_W    = 3;
  localparam int IDX_W     = $clog2(LINES);
  localparam int TAG_W     = ADDR_W - IDX_W - OFS_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB_REQ    = 2'd1,
    FILL_REQ  = 2'd2,
    FILL_DONE = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFS_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WSEL_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write.
// Fills overwrite the whole line; store hits patch one word and mark it dirty.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic                 word_en,
  input  logic [WSEL_W-1:0]    word_sel,
  input  logic [31:0]          word_data
);

  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [TAG_W-1:0]     tags  [LINES];
  logic [LINE_BITS-1:0] lines [LINES];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = lines[idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; a cleared valid bit makes them unreachable.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tags[idx]  <= fill_tag;
      lines[idx] <= fill_line;
    end else if (word_en) begin
      lines[idx][{word_sel, 5'b0} +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
//   state     | meaning
//   IDLE      | serve hits combinationally; a miss stalls and leaves
//   WB_REQ    | write the dirty victim line back, wait for ack
//   FILL_REQ  | read the new line, install it on ack
//   FILL_DONE | one settle cycle; the held access then hits in IDLE
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_read_i,
  input  logic                 cpu_write_i,
  output logic [31:0]          cpu_data_o,
  output logic                 stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_t state, next_state;

  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    wsel;
  logic                 req;
  logic                 hit;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 fill_en;
  logic                 word_en;
  logic                 rd_hit;
  logic                 unused_ok;

  assign tag       = addr_tag(cpu_addr_i);
  assign idx       = addr_idx(cpu_addr_i);
  assign wsel      = addr_word(cpu_addr_i);
  assign unused_ok = ^cpu_addr_i[1:0];

  assign req = cpu_read_i | cpu_write_i;
  assign hit = rd_valid & (rd_tag == tag);

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (mem_data_i),
    .word_en   (word_en),
    .word_sel  (wsel),
    .word_data (cpu_data_i)
  );

  always_comb begin
    next_state = state;
    stall_o    = 1'b1;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    rd_hit     = 1'b0;
    case (state)
      IDLE: begin
        stall_o = req & ~hit;
        // A simultaneous read+write is a store, so it never returns load data.
        word_en = cpu_write_i & hit;
        rd_hit  = cpu_read_i & ~cpu_write_i & hit;
        if (req && !hit) begin
          next_state = (rd_valid && rd_dirty) ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        if (mem_ack_i) next_state = FILL_REQ;
      end
      FILL_REQ: begin
        if (mem_ack_i) begin
          fill_en    = ~rst_i;
          next_state = FILL_DONE;
        end
      end
      FILL_DONE: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state)
      WB_REQ: begin
        mem_addr_o = line_addr(rd_tag, idx);
        mem_data_o = rd_line;
      end
      FILL_REQ: mem_addr_o = line_addr(tag, idx);
      default: ;
    endcase
  end

  assign cpu_data_o = rd_hit ? rd_line[{wsel, 5'b0} +: 32] : 32'd0;

  // Request strobes are registered from next_state so they are valid in the
  // first cycle of a request state and drop the cycle after the final ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      state        <= next_state;
      mem_enable_o <= (next_state == WB_REQ) || (next_state == FILL_REQ);
      mem_write_o  <= (next_state == WB_REQ);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: transaction-level cache model, a
// fixed-latency memory responder, directed scenarios and randomized accesses.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_rdata;
  logic         stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_wdata),
    .cpu_read_i   (cpu_read),
    .cpu_write_i  (cpu_write),
    .cpu_data_o   (cpu_rdata),
    .stall_o      (stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  int tests = 0;
  int fails = 0;

  // cache model
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_line  [32];

  // backing memory, keyed by line number (byte address >> 5)
  logic [255:0] mem_lines [int unsigned];
  int           lat;
  int           mcnt;
  bit           mturn;

  // outstanding miss as the model sees it
  bit           miss_on;
  int           miss_k, miss_len;
  bit           miss_dirty;
  logic [31:0]  miss_old_addr, miss_new_addr;
  logic [255:0] miss_old_line;

  // request trace
  int           n_rd_req, n_wr_req;
  logic [31:0]  last_rd_addr, last_wr_addr;
  logic [255:0] last_wr_data;
  bit           prev_rd_en, prev_wr_en;

  logic         s_stall, s_en, s_wr;
  logic [31:0]  s_data, s_addr;
  logic [255:0] s_mdata;

  function automatic logic [255:0] init_line(input int unsigned ln);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = ln * 32'h9E37_79B9 + w * 32'h0101_0101 + 32'h1357;
    return r;
  endfunction

  function automatic logic [255:0] mem_get(input int unsigned ln);
    if (mem_lines.exists(ln)) return mem_lines[ln];
    return init_line(ln);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check();
    logic [4:0]  idx;
    logic [21:0] tag;
    int          w;
    bit          req, hit, en, wr;
    logic [31:0] addr;
    s_stall = stall_o; s_data = cpu_rdata; s_en = mem_enable_o; s_wr = mem_write_o;
    s_addr = mem_addr_o; s_mdata = mem_data_o;
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      miss_on = 0;
      return;
    end
    idx = cpu_addr[9:5];
    tag = cpu_addr[31:10];
    w   = int'(cpu_addr[4:2]);
    req = cpu_read | cpu_write;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!miss_on && req && !hit) begin
      miss_on       = 1;
      miss_k        = 0;
      miss_dirty    = m_valid[idx] && m_dirty[idx];
      miss_len      = miss_dirty ? 2*lat + 3 : lat + 2;
      miss_old_addr = {m_tag[idx], idx, 5'b0};
      miss_new_addr = {cpu_addr[31:5], 5'b0};
      miss_old_line = m_line[idx];
    end
    if (miss_on) begin
      en = 0; wr = 0; addr = 0;
      if (miss_dirty && miss_k >= 1 && miss_k <= lat) begin
        en = 1; wr = 1; addr = miss_old_addr;
      end else if (miss_dirty && miss_k >= lat + 1 && miss_k <= 2*lat + 1) begin
        en = 1; addr = miss_new_addr;
      end else if (!miss_dirty && miss_k >= 1 && miss_k <= lat) begin
        en = 1; addr = miss_new_addr;
      end
      chk("miss_stall", stall_o, 1'b1);
      chk("miss_rdata", cpu_rdata, 32'd0);
      chk("miss_mem_en", mem_enable_o, en);
      chk("miss_mem_wr", mem_write_o, wr);
      if (en) chk("miss_mem_addr", mem_addr_o, addr);
      if (en && wr) chk("wb_data", mem_data_o, miss_old_line);
      miss_k++;
      if (miss_k == miss_len) begin
        m_line[idx]  = mem_get(miss_new_addr >> 5);
        m_tag[idx]   = tag;
        m_valid[idx] = 1;
        m_dirty[idx] = 0;
        miss_on      = 0;
      end
    end else begin
      chk("idle_stall", stall_o, 1'b0);
      chk("idle_mem_en", mem_enable_o, 1'b0);
      chk("rdata", cpu_rdata, (cpu_read && !cpu_write && hit) ? m_line[idx][w*32 +: 32] : 32'd0);
      if (cpu_write && hit) begin
        m_line[idx][w*32 +: 32] = cpu_wdata;
        m_dirty[idx] = 1;
      end
    end
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic step();
    bit rd_en, wr_en;
    mem_ack_i = 1'b0;
    for (int i = 0; i < 8; i++) mem_data_i[i*32 +: 32] = $urandom;
    rd_en = !rst_i && mem_enable_o && !mem_write_o;
    wr_en = !rst_i && mem_enable_o && mem_write_o;
    if (rd_en && !prev_rd_en) begin n_rd_req++; last_rd_addr = mem_addr_o; end
    if (wr_en && !prev_wr_en) begin
      n_wr_req++; last_wr_addr = mem_addr_o; last_wr_data = mem_data_o;
    end
    if (rd_en || wr_en) begin
      if (mturn) mturn = 0;
      else begin
        mcnt++;
        if (mcnt >= lat) begin
          mem_ack_i = 1'b1;
          mcnt = 0;
          mturn = 1;
          if (wr_en) mem_lines[mem_addr_o >> 5] = mem_data_o;
          else mem_data_i = mem_get(mem_addr_o >> 5);
        end
      end
    end else begin
      mcnt = 0; mturn = 0;
    end
    prev_rd_en = rd_en;
    prev_wr_en = wr_en;
    #4;
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                        output int stalls, output logic [31:0] rdata);
    bit done = 0;
    cpu_addr = a; cpu_wdata = d; cpu_read = rd; cpu_write = wr;
    stalls = 0; rdata = 32'd0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (!s_stall) begin rdata = s_data; done = 1; end
      else stalls++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL access_timeout addr=%0h stall still high, required low within 200 cycles", a);
    end
    cpu_read = 0; cpu_write = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int           st;
    int           nr, nw;
    logic [31:0]  rd;
    logic [255:0] ln;
    rst_i = 1; cpu_addr = 0; cpu_wdata = 0; cpu_read = 0; cpu_write = 0;
    mem_ack_i = 0; mem_data_i = 0; lat = 10; mcnt = 0; mturn = 0;
    n_rd_req = 0; n_wr_req = 0; prev_rd_en = 0; prev_wr_en = 0; miss_on = 0;
    last_rd_addr = 0; last_wr_addr = 0; last_wr_data = 0;
    ln = init_line(2); ln[31:0] = 32'hDEAD_BEEF; mem_lines[2] = ln;

    @(posedge clk); #1;
    step(); step();
    rst_i = 0;
    step();
    chk("rst_stall", s_stall, 1'b0);
    chk("rst_mem_en", s_en, 1'b0);
    chk("rst_mem_wr", s_wr, 1'b0);
    chk("rst_rdata", s_data, 32'd0);
    chk("rst_mem_addr", s_addr, 32'd0);
    chk("rst_mem_data", s_mdata, 256'd0);

    // cold load miss
    nr = n_rd_req;
    access(32'h40, 0, 1, 0, st, rd);
    chk("cold_stall_cycles", st, 12);
    chk("cold_rdata", rd, 32'hDEAD_BEEF);
    chk("cold_rd_reqs", n_rd_req - nr, 1);
    chk("cold_rd_addr", last_rd_addr, 32'h40);

    // repeat load hits
    nr = n_rd_req;
    access(32'h40, 0, 1, 0, st, rd);
    chk("hit_stall_cycles", st, 0);
    chk("hit_rdata", rd, 32'hDEAD_BEEF);
    chk("hit_no_req", n_rd_req - nr, 0);

    // store hit then load
    nr = n_rd_req; nw = n_wr_req;
    access(32'h44, 32'h1234_5678, 0, 1, st, rd);
    chk("st_hit_stall", st, 0);
    access(32'h44, 0, 1, 0, st, rd);
    chk("st_ld_rdata", rd, 32'h1234_5678);
    chk("st_no_traffic", (n_rd_req - nr) + (n_wr_req - nw), 0);

    // conflict miss on a dirty line
    nr = n_rd_req; nw = n_wr_req;
    access(32'h1040, 0, 1, 0, st, rd);
    chk("dirty_stall_cycles", st, 23);
    chk("dirty_wr_reqs", n_wr_req - nw, 1);
    chk("dirty_wr_addr", last_wr_addr, 32'h40);
    chk("dirty_wr_word1", last_wr_data[63:32], 32'h1234_5678);
    chk("dirty_wr_word0", last_wr_data[31:0], 32'hDEAD_BEEF);
    chk("dirty_rd_addr", last_rd_addr, 32'h1040);
    chk("dirty_rd_reqs", n_rd_req - nr, 1);
    ln = init_line(32'h1040 >> 5);
    chk("dirty_rdata", rd, ln[31:0]);

    // store miss to a clean line merges after the fill
    access(32'h88, 32'hCAFE_F00D, 0, 1, st, rd);
    chk("stmiss_stall_cycles", st, 12);
    ln = init_line(4); ln[95:64] = 32'hCAFE_F00D;
    for (int w = 0; w < 8; w++) begin
      access(32'h80 + w*4, 0, 1, 0, st, rd);
      chk("stmiss_word", rd, ln[w*32 +: 32]);
    end
    access(32'h1088, 0, 1, 0, st, rd);
    chk("stmiss_dirty_stall", st, 23);
    chk("stmiss_wb_addr", last_wr_addr, 32'h80);
    chk("stmiss_wb_line", last_wr_data, ln);

    // reset in the middle of a fill
    cpu_addr = 32'h2100; cpu_read = 1; cpu_write = 0;
    for (int i = 0; i < 4; i++) step();
    rst_i = 1; cpu_read = 0;
    step();
    rst_i = 0;
    step();
    chk("midrst_mem_en", s_en, 1'b0);
    chk("midrst_stall", s_stall, 1'b0);
    nr = n_rd_req;
    access(32'h2100, 0, 1, 0, st, rd);
    chk("midrst_stall_cycles", st, 12);
    chk("midrst_rd_reqs", n_rd_req - nr, 1);
    chk("midrst_rd_addr", last_rd_addr, 32'h2100);
    ln = init_line(32'h2100 >> 5);
    chk("midrst_rdata", rd, ln[31:0]);

    // randomized traffic over a few conflicting lines
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      lat = $urandom_range(1, 5);
      a = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2)
          | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op == 9) step();
      else access(a, $urandom, (op < 4) || (op == 8), (op >= 4), st, rd);
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
